flt2int_iter: RTL and testbench
===============================

# flt2int_iter

Parametrised, iterative float-to-signed-magnitude-integer converter. It generalises the fixed half-precision converter to any IEEE-style EXP_W/MANT_W input and INT_W output, and adds a valid/ready handshake, a selectable rounding mode and status flags. It performs one alignment shift per clock so it can sit beside data_mem as a multi-cycle execution unit of the processor datapath.

## Interface
- EXP_W, 5, exponent field width
- MANT_W, 10, stored mantissa width (hidden bit not stored)
- BIAS, 15, exponent bias
- INT_W, 16, result width: 1 sign bit + INT_W-1 magnitude bits; legal only if INT_W-1 >= MANT_W+1
- clk_i  input  1  clock; all logic on posedge
- reset_i  input  1  synchronous, active-high reset
- in_valid_i  input  1  operand valid
- in_ready_o  output  1  unit can accept an operand
- flt_i  input  1+EXP_W+MANT_W  {sign, exp, mant}
- rnd_mode_i  input  1  0 = round-nearest-even, 1 = truncate toward zero; sampled with the operand
- out_valid_o  output  1  result valid
- out_ready_i  input  1  consumer accepts the result
- int_o  output  INT_W  {sign, magnitude}
- ovf_o  output  1  result saturated (inf, NaN or out of range)
- inexact_o  output  1  nonzero bits discarded (excluding saturation)
- unf_o  output  1  nonzero input produced zero magnitude

## Operation
- States: IDLE, ALIGN, ROUND, DONE. in_ready_o = (state==IDLE). out_valid_o = (state==DONE).
- Accept: in_valid_i & in_ready_o in IDLE. Latch sign, exp e, {1,mant} (hidden bit 0 if e==0), rnd mode. Classify:
  - Special, next state ROUND with zero shift count, result forced:
    - e all-ones, or e-BIAS >= INT_W-1: magnitude all ones, ovf=1.
    - e==0 and mant==0: zero, no flags.
    - Otherwise e < BIAS-1 (value < 0.5): zero, inexact=1, unf=1.
  - Normal case: left count L = e-BIAS-MANT_W if > 0; right count R = BIAS+MANT_W-e if > 0. Next state ALIGN, or ROUND if the count is 0.
- ALIGN: each cycle, shift the accumulator one bit, decrement the count, and go to ROUND when the count reaches 0. The accumulator is INT_W-1 magnitude bits plus guard g plus sticky s.
  - Left shifts fill with 0.
  - Right shifts move the LSB into g and OR the old g into s.
- ROUND: l = magnitude LSB.
  - Mode 0 increments if g & (l | s). Mode 1 never increments.
  - inexact = g|s. unf = 1 if the input was nonzero and the final magnitude is 0.
  - If the increment carries out of INT_W-1 bits: saturate to all ones, ovf=1, inexact=0.
- Sign always equals the input sign, including signed zero (0x8000) and saturation (0xFFFF / 0x7FFF at defaults).
- DONE: int_o and the flags are held stable until out_ready_i=1. Then go to IDLE; in_ready_o rises the following cycle. Input and output transfers never overlap.
- in_valid_i while not IDLE is ignored. flt_i and rnd_mode_i are don't-care outside the accept cycle.

## Timing
- Reset (synchronous, active-high): state=IDLE; int_o=0, ovf_o=0, inexact_o=0, unf_o=0, out_valid_o=0. in_ready_o=1 in the first cycle after reset deasserts.
- Latency from the accept edge to out_valid_o high = 2 + N cycles, where N is the shift count (L or R). Special cases have N=0.
- Worst case at defaults: R = MANT_W+1 = 11 (e=14), giving 13 cycles.
- Reset asserted in any state (mid-ALIGN, DONE awaiting ready) aborts the operation. The result is never presented, and the unit is in IDLE with outputs cleared on the next edge.
- out_ready_i may be high before out_valid_o. The transfer occurs on the first edge where both are high.

## Test plan
- 0x4AC0 (13.5), mode 0 -> int_o=0x000E, inexact=1, out_valid_o exactly 9 cycles after accept. 0x4A40 (12.5), mode 0 -> 0x000C (tie to even). 0x4A40, mode 1 -> 0x000C with inexact=1.
- 0x7400 (16384) -> 0x4000, no flags, latency 6. 0xF800 (-32768) -> 0xFFFF, ovf=1, latency 2. 0x7C00 (+inf) -> 0x7FFF, ovf=1.
- Near-zero cases:
  - 0x3800 (0.5), mode 0 -> 0x0000, inexact=1, unf=1.
  - 0x3A00 (0.75) -> 0x0001, inexact=1.
  - 0x2000 (~0.0078) -> 0x0000, unf=1, latency 2.
  - 0x8000 -> 0x8000, no flags.
- Backpressure: hold out_ready_i=0 for 5 cycles with in_valid_i=1 and a second operand present -> int_o and flags stable, in_ready_o=0, second operand not accepted. Raise out_ready_i -> IDLE, then the second operand is accepted one cycle later.
- Assert reset_i during ALIGN of 0x4AC0 -> no out_valid_o pulse, all outputs 0, in_ready_o=1 next cycle. A following 0x3C00 -> 0x0001 in 2+10=12 cycles.
- Parameter sweep: EXP_W=8, MANT_W=23, BIAS=127, INT_W=32 with a random stream checked against a reference model (RNE and truncate), including 2^31 -> saturate and 2147483520.0 -> exact.

Source files
------------

// File: rtl/flt2int_iter.sv
// flt2int_iter
// Iterative converter from an IEEE-style float {sign, exp, mant} to a
// sign-magnitude integer {sign, magnitude}. It shifts the significand one
// bit per clock, then rounds to nearest-even or truncates toward zero, and
// reports saturation, inexact and underflow flags.
//
// Handshake: an operand transfers on a rising edge where in_valid_i and
// in_ready_o are both high. A result transfers on a rising edge where
// out_valid_o and out_ready_i are both high. in_ready_o is high only in
// IDLE and out_valid_o is high only in DONE, so the two transfers never
// overlap. int_o and the flags are held stable while out_valid_o is high.
//
// Ports:
//   clk_i        clock, rising edge
//   reset_i      synchronous active-high reset
//   in_valid_i   operand valid
//   in_ready_o   unit idle and able to accept an operand
//   flt_i        {sign, exp[EXP_W], mant[MANT_W]}
//   rnd_mode_i   0 = round-nearest-even, 1 = truncate; captured with flt_i
//   out_valid_o  result valid
//   out_ready_i  consumer takes the result
//   int_o        {sign, magnitude[INT_W-1]}
//   ovf_o        result saturated (inf, NaN or out of range)
//   inexact_o    nonzero bits were discarded (never set with ovf_o)
//   unf_o        nonzero input produced a zero magnitude
//   dbg_state_o  current FSM state, for observation only
module flt2int_iter #(
  parameter int EXP_W  = 5,
  parameter int MANT_W = 10,
  parameter int BIAS   = 15,
  parameter int INT_W  = 16
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [EXP_W+MANT_W:0]   flt_i,
  input  logic                    rnd_mode_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [INT_W-1:0]        int_o,
  output logic                    ovf_o,
  output logic                    inexact_o,
  output logic                    unf_o,
  output logic [1:0]              dbg_state_o
);

  localparam int MAG_W = INT_W - 1;
  localparam int CNT_W = $clog2(INT_W + MANT_W + 2);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Accumulator: magnitude plus guard and sticky bits.
  logic [MAG_W-1:0] mag_q, mag_d;
  logic             g_q, g_d;
  logic             s_q, s_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             left_q, left_d;   // shift direction: 1 = left
  logic             rnd_q, rnd_d;
  logic             sign_q, sign_d;
  logic             nz_q, nz_d;       // input was nonzero
  logic             sat_q, sat_d;     // saturation decided at accept time
  logic [INT_W-1:0] int_q, int_d;
  logic             ovf_q, ovf_d;
  logic             inex_q, inex_d;
  logic             unf_q, unf_d;

  // Operand fields and classification, valid in the accept cycle.
  logic [EXP_W-1:0]  exp_f;
  logic [MANT_W-1:0] mant_f;
  logic              sign_f;
  logic [MANT_W:0]   sig_f;
  int                e_int;
  int                shift_l;         // >0: left shift count, <0: right shift count
  logic              is_sat, is_zero, is_tiny;

  assign exp_f   = flt_i[MANT_W +: EXP_W];
  assign mant_f  = flt_i[MANT_W-1:0];
  assign sign_f  = flt_i[EXP_W+MANT_W];
  assign sig_f   = {exp_f != '0, mant_f};
  assign e_int   = int'(exp_f);
  assign shift_l = e_int - BIAS - MANT_W;
  assign is_sat  = (&exp_f) || (e_int - BIAS >= INT_W - 1);
  assign is_zero = (exp_f == '0) && (mant_f == '0);
  assign is_tiny = (e_int < BIAS - 1);

  logic             inc;
  logic [MAG_W:0]   sum;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    g_d     = g_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    left_d  = left_q;
    rnd_d   = rnd_q;
    sign_d  = sign_q;
    nz_d    = nz_q;
    sat_d   = sat_q;
    int_d   = int_q;
    ovf_d   = ovf_q;
    inex_d  = inex_q;
    unf_d   = unf_q;
    inc     = 1'b0;
    sum     = '0;

    unique case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          sign_d = sign_f;
          rnd_d  = rnd_mode_i;
          nz_d   = !is_zero;
          mag_d  = MAG_W'(sig_f);
          g_d    = 1'b0;
          s_d    = 1'b0;
          sat_d  = 1'b0;
          cnt_d  = '0;
          left_d = 1'b0;
          if (is_sat) begin
            sat_d   = 1'b1;
            mag_d   = '1;
            state_d = ROUND;
          end else if (is_zero) begin
            mag_d   = '0;
            state_d = ROUND;
          end else if (is_tiny) begin
            // Below one half: the sticky bit alone marks it inexact and
            // can never cause a round-up since the guard is clear.
            mag_d   = '0;
            s_d     = 1'b1;
            state_d = ROUND;
          end else if (shift_l > 0) begin
            left_d  = 1'b1;
            cnt_d   = CNT_W'(shift_l);
            state_d = ALIGN;
          end else if (shift_l < 0) begin
            cnt_d   = CNT_W'(-shift_l);
            state_d = ALIGN;
          end else begin
            state_d = ROUND;
          end
        end
      end

      ALIGN: begin
        if (left_q) begin
          mag_d = {mag_q[MAG_W-2:0], 1'b0};
        end else begin
          mag_d = {1'b0, mag_q[MAG_W-1:1]};
          g_d   = mag_q[0];
          s_d   = s_q | g_q;
        end
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = ROUND;
      end

      ROUND: begin
        inc = ~rnd_q & g_q & (mag_q[0] | s_q);
        sum = {1'b0, mag_q} + {{MAG_W{1'b0}}, inc};
        if (sat_q || sum[MAG_W]) begin
          int_d  = {sign_q, {MAG_W{1'b1}}};
          ovf_d  = 1'b1;
          inex_d = 1'b0;
          unf_d  = 1'b0;
        end else begin
          int_d  = {sign_q, sum[MAG_W-1:0]};
          ovf_d  = 1'b0;
          inex_d = g_q | s_q;
          unf_d  = nz_q && (sum[MAG_W-1:0] == '0);
        end
        state_d = DONE;
      end

      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      mag_q   <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      rnd_q   <= 1'b0;
      sign_q  <= 1'b0;
      nz_q    <= 1'b0;
      sat_q   <= 1'b0;
      int_q   <= '0;
      ovf_q   <= 1'b0;
      inex_q  <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      g_q     <= g_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      left_q  <= left_d;
      rnd_q   <= rnd_d;
      sign_q  <= sign_d;
      nz_q    <= nz_d;
      sat_q   <= sat_d;
      int_q   <= int_d;
      ovf_q   <= ovf_d;
      inex_q  <= inex_d;
      unf_q   <= unf_d;
    end
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign int_o       = int_q;
  assign ovf_o       = ovf_q;
  assign inexact_o   = inex_q;
  assign unf_o       = unf_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_flt2int_iter.sv
// Bench for flt2int_iter: directed half-precision vectors with hand-computed
// results on a default instance, plus a single-precision / 32-bit instance
// driven by directed and random operands against a fixed-point model.
module tb_flt2int_iter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- default instance (16-bit) ----------------
  logic        v0, rdy0, m0, ov0, ordy0, ovf0, ix0, uf0;
  logic [15:0] f0, i0;
  logic [1:0]  st0;

  flt2int_iter u_dut0 (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(v0), .in_ready_o(rdy0), .flt_i(f0), .rnd_mode_i(m0),
    .out_valid_o(ov0), .out_ready_i(ordy0), .int_o(i0),
    .ovf_o(ovf0), .inexact_o(ix0), .unf_o(uf0), .dbg_state_o(st0)
  );

  // ---------------- single precision instance (32-bit) ----------------
  logic        v1, rdy1, m1, ov1, ordy1, ovf1, ix1, uf1;
  logic [31:0] f1, i1;
  logic [1:0]  st1;

  flt2int_iter #(.EXP_W(8), .MANT_W(23), .BIAS(127), .INT_W(32)) u_dut1 (
    .clk_i(clk), .reset_i(rst),
    .in_valid_i(v1), .in_ready_o(rdy1), .flt_i(f1), .rnd_mode_i(m1),
    .out_valid_o(ov1), .out_ready_i(ordy1), .int_o(i1),
    .ovf_o(ovf1), .inexact_o(ix1), .unf_o(uf1), .dbg_state_o(st1)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [34:0] exp_q[$];   // {int[32], ovf, inexact, unf}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: scale the significand into a fixed-point value with 64
  // fraction bits, then round from the integer/fraction split.
  function automatic logic [34:0] model32(input logic [31:0] f, input logic mode);
    logic         s, half, rest, inc;
    int           e, sh;
    logic [23:0]  sig;
    logic [191:0] fx;
    logic [127:0] ip, res;
    s   = f[31];
    e   = int'(f[30:23]);
    sig = {e != 0, f[22:0]};
    if (e == 255) return {s, 31'h7FFF_FFFF, 3'b100};
    sh = e - 127 - 23;
    if (sh >= -64) begin
      fx   = 192'(sig) << (64 + sh);
      ip   = fx[191:64];
      half = fx[63];
      rest = |fx[62:0];
    end else begin
      ip   = '0;
      half = 1'b0;
      rest = |sig;
    end
    inc = !mode && half && (ip[0] || rest);
    res = ip + 128'(inc);
    if (res >= 128'h8000_0000) return {s, 31'h7FFF_FFFF, 3'b100};
    return {s, res[30:0], 1'b0, half | rest, (f[30:0] != 0) && (res == 0)};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic wait_out0(output int n);
    n = 1;
    while (!ov0 && n < 64) begin @(posedge clk); #1; n++; end
  endtask

  task automatic op16(input string tag, input logic [15:0] f, input logic mode,
                      input logic [15:0] e_int, input logic [2:0] e_fl, input int e_lat);
    int n;
    check({tag, "/rdy"}, 64'(rdy0), 64'd1);
    v0 = 1'b1; f0 = f; m0 = mode;
    @(posedge clk); #1;
    v0 = 1'b0; f0 = 16'($urandom); m0 = 1'($urandom);
    wait_out0(n);
    check({tag, "/lat"}, 64'(n), 64'(e_lat));
    check({tag, "/int"}, 64'(i0), 64'(e_int));
    check({tag, "/flags"}, 64'({ovf0, ix0, uf0}), 64'(e_fl));
    ordy0 = 1'b1; @(posedge clk); #1; ordy0 = 1'b0;
    check({tag, "/idle"}, 64'({ov0, rdy0}), 64'(2'b01));
  endtask

  task automatic op32(input string tag, input logic [31:0] f, input logic mode,
                      input logic [34:0] e_res);
    int n;
    logic [34:0] e;
    exp_q.push_back(e_res);
    v1 = 1'b1; f1 = f; m1 = mode;
    @(posedge clk); #1;
    v1 = 1'b0; f1 = $urandom;
    n = 1;
    while (!ov1 && n < 64) begin @(posedge clk); #1; n++; end
    check({tag, "/valid"}, 64'(ov1), 64'd1);
    e = exp_q.pop_front();
    if ({i1, ovf1, ix1, uf1} !== e)
      $display("  operand %08h mode %0d", f, mode);
    check({tag, "/res"}, 64'({i1, ovf1, ix1, uf1}), 64'(e));
    ordy1 = 1'b1; @(posedge clk); #1; ordy1 = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int   n;
    logic seen;
    logic [31:0] f;
    logic        md;
    int          e;

    rst = 1'b1;
    v0 = 1'b0; f0 = '0; m0 = 1'b0; ordy0 = 1'b0;
    v1 = 1'b0; f1 = '0; m1 = 1'b0; ordy1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset/outs0", 64'({ov0, i0, ovf0, ix0, uf0}), 64'd0);
    check("reset/outs1", 64'({ov1, i1, ovf1, ix1, uf1}), 64'd0);
    rst = 1'b0;
    check("reset/rdy", 64'({rdy0, rdy1}), 64'(2'b11));
    check("reset/state", 64'(st0), 64'd0);

    // Directed half-precision vectors.
    op16("13.5_rne",   16'h4AC0, 1'b0, 16'h000E, 3'b010, 9);
    op16("13.5_trn",   16'h4AC0, 1'b1, 16'h000D, 3'b010, 9);
    op16("12.5_rne",   16'h4A40, 1'b0, 16'h000C, 3'b010, 9);
    op16("12.5_trn",   16'h4A40, 1'b1, 16'h000C, 3'b010, 9);
    op16("neg13.5",    16'hCAC0, 1'b0, 16'h800E, 3'b010, 9);
    op16("16384",      16'h7400, 1'b0, 16'h4000, 3'b000, 6);
    op16("32752",      16'h77FF, 1'b0, 16'h7FF0, 3'b000, 6);
    op16("neg32768",   16'hF800, 1'b0, 16'hFFFF, 3'b100, 2);
    op16("max_fin",    16'h7BFF, 1'b0, 16'h7FFF, 3'b100, 2);
    op16("pos_inf",    16'h7C00, 1'b0, 16'h7FFF, 3'b100, 2);
    op16("nan",        16'hFE00, 1'b1, 16'hFFFF, 3'b100, 2);
    op16("0.5_rne",    16'h3800, 1'b0, 16'h0000, 3'b011, 13);
    op16("0.75_rne",   16'h3A00, 1'b0, 16'h0001, 3'b010, 13);
    op16("0.75_trn",   16'h3A00, 1'b1, 16'h0000, 3'b011, 13);
    op16("0.9995_rne", 16'h3BFF, 1'b0, 16'h0001, 3'b010, 13);
    op16("1.0",        16'h3C00, 1'b0, 16'h0001, 3'b000, 12);
    op16("tiny",       16'h2000, 1'b0, 16'h0000, 3'b011, 2);
    op16("denorm",     16'h0001, 1'b0, 16'h0000, 3'b011, 2);
    op16("pos_zero",   16'h0000, 1'b0, 16'h0000, 3'b000, 2);
    op16("neg_zero",   16'h8000, 1'b0, 16'h8000, 3'b000, 2);

    // Backpressure with a second operand waiting.
    v0 = 1'b1; f0 = 16'h4AC0; m0 = 1'b0;
    @(posedge clk); #1;
    f0 = 16'h3C00;
    wait_out0(n);
    check("bp/lat", 64'(n), 64'd9);
    repeat (5) begin
      @(posedge clk); #1;
      check("bp/hold", 64'({ov0, rdy0, i0, ovf0, ix0, uf0}), 64'({1'b1, 1'b0, 16'h000E, 3'b010}));
    end
    ordy0 = 1'b1; @(posedge clk); #1; ordy0 = 1'b0;
    check("bp/idle", 64'({ov0, rdy0}), 64'(2'b01));
    @(posedge clk); #1;
    v0 = 1'b0;
    check("bp/acc2", 64'(rdy0), 64'd0);
    wait_out0(n);
    check("bp2/lat", 64'(n), 64'd12);
    check("bp2/int", 64'({i0, ovf0, ix0, uf0}), 64'({16'h0001, 3'b000}));
    ordy0 = 1'b1; @(posedge clk); #1; ordy0 = 1'b0;

    // Reset in the middle of ALIGN.
    v0 = 1'b1; f0 = 16'h4AC0; m0 = 1'b0;
    @(posedge clk); #1; v0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_mid/state", 64'(st0), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid/outs", 64'({ov0, i0, ovf0, ix0, uf0}), 64'd0);
    check("rst_mid/rdy", 64'(rdy0), 64'd1);
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin @(posedge clk); #1; if (ov0) seen = 1'b1; end
    check("rst_mid/no_valid", 64'(seen), 64'd0);
    op16("after_rst", 16'h3C00, 1'b0, 16'h0001, 3'b000, 12);

    // Single precision, hand-computed boundaries.
    op32("2^31",     32'h4F00_0000, 1'b0, {32'h7FFF_FFFF, 3'b100});
    op32("neg2^31",  32'hCF00_0000, 1'b1, {32'hFFFF_FFFF, 3'b100});
    op32("max_exact",32'h4EFF_FFFF, 1'b0, {32'h7FFF_FF80, 3'b000});
    op32("2.5_rne",  32'h4020_0000, 1'b0, {32'h0000_0002, 3'b010});
    op32("3.5_rne",  32'h4060_0000, 1'b0, {32'h0000_0004, 3'b010});
    op32("neg_zero", 32'h8000_0000, 1'b0, {32'h8000_0000, 3'b000});

    // Single precision, random operands against the model.
    for (int k = 0; k < 160; k++) begin
      e  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(118, 160));
      f  = {1'($urandom), 8'(e), 23'($urandom)};
      if ($urandom_range(0, 3) == 0) f[10:0] = '0;   // more exact and tie cases
      md = 1'($urandom);
      op32("rand", f, md, model32(f, md));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
